l1_refill_biu: RTL
==================

// Module: l1_refill_biu
// PURPOSE
//  Bus-interface/refill engine directly below the L1 I-cache: services its read_line_req / read_req / write_through_req
//  strobes over a simple 8-bit request/ack memory bus; streams a 256-byte line back as byte beats (line_data, addr_count,
//  line_write), then pulses cache_entry_refill + trans_rdy. Single reads/writes pass through uncached. Errors -> bus_error.
// PARAMETERS
//  ADDR_WIDTH   24    physical byte address width
//  LINE_WID     8     log2(line bytes); line = 256 B, aligned on pa[ADDR_WIDTH-1:LINE_WID]
//  TIMEOUT_CYC  255   max cycles waiting for bus_ack per beat (only with L1_BIU_TIMEOUT_EN)
// PORTS
//  clk                 in   1         clock
//  rst                 in   1         synchronous, active-high reset
//  read_line_req       in   1         L1 requests line refill at pa
//  read_req            in   1         L1 requests one uncached byte read at pa
//  write_through_req   in   1         L1 requests one byte write of wt_data at pa
//  pa                  in   ADDR_WIDTH  request byte address
//  wt_data             in   8         write-through data
//  line_data           out  8         returned byte (line beat or single read)
//  addr_count          out  LINE_WID  byte offset within line of current beat
//  line_write          out  1         1-cycle strobe: write line_data at addr_count
//  cache_entry_refill  out  1         1-cycle strobe: whole line landed, update tag
//  trans_rdy           out  1         1-cycle strobe: transaction complete
//  bus_error           out  1         1-cycle strobe: transaction failed
//  bus_req/bus_we      out  1/1       bus cycle request / write enable
//  bus_addr            out  ADDR_WIDTH  bus byte address
//  bus_wdata           out  8         bus write data
//  bus_rdata           in   8         bus read data, valid with bus_ack
//  bus_ack/bus_err     in   1/1       1-cycle beat completion / beat failure (err wins if both)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (bus_addr, addr_count, line_data = 0). Reset mid-transfer drops bus_req next edge,
//   no refill/trans_rdy/bus_error emitted, partial line abandoned.
//  States: IDLE, LINE, SRD, SWR, DONE, ERR. All outputs registered.
//  IDLE: sample reqs, priority read_line_req > read_req > write_through_req; latch pa (line base = {pa[hi:8],8'h00}),
//   wt_data; count<=0. Requests ignored in every other state; once launched a transfer always runs to DONE/ERR.
//  LINE: bus_req=1, bus_we=0, bus_addr={base,count}. On bus_ack: next cycle line_write=1, line_data=bus_rdata,
//   addr_count=count; count++ (wraps 255->0 = last beat). bus_req stays high across beats (one beat per ack, min
//   2 cycles/beat). After ack of offset 255 -> DONE with cache_entry_refill=1 and trans_rdy=1 same cycle.
//  SRD: one read beat at pa; on ack line_data=bus_rdata, -> DONE (trans_rdy only, no line_write).
//  SWR: bus_we=1, bus_wdata=wt_data, one beat; on ack -> DONE (trans_rdy only).
//  DONE: strobes high exactly 1 cycle -> IDLE. L1 drops its request on the same edge, so no relaunch.
//  ERR: entered on bus_err in LINE/SRD/SWR; bus_req drops; bus_error=1 one cycle, no refill, no trans_rdy -> IDLE.
//  Latency: line = 256 beats; uncontended ack-next-cycle bus gives 2 cycles/beat + 1 DONE cycle.
// CONFIGURATION
//  L1_BIU_TIMEOUT_EN defined: per-beat watchdog counts cycles with bus_req=1 and no ack/err; reaching TIMEOUT_CYC
//   forces ERR exactly as bus_err; counter cleared on each ack and in IDLE.
//  Undefined: no watchdog, BIU waits forever for ack/err; TIMEOUT_CYC unused.
// STRUCTURE
//  l1_biu_pkg: state encoding localparams, LINE_WID/line-bytes constants, shared with the L1 cache.
//  Sub-module l1_biu_watchdog (counter + compare, instantiated only under L1_BIU_TIMEOUT_EN).
// TESTING
//  1 Line refill pa=24'h012345, bus acks next cycle, rdata=offset^8'hA5 -> 256 line_write, addr_count 0..255, bus_addr
//    24'h012300..0123FF, then cache_entry_refill=trans_rdy=1 in one cycle.
//  2 read_req pa=24'h00F001, rdata=8'h3C -> single beat, line_data=8'h3C, trans_rdy 1 cycle, line_write never.
//  3 write_through_req pa=24'h800010 wt_data=8'h5A -> bus_we=1, bus_wdata=8'h5A, trans_rdy after ack.
//  4 bus_err on beat 17 of line -> bus_error 1 cycle, bus_req low, no cache_entry_refill, next req serviced.
//  5 rst asserted at beat 100 -> all outputs 0 next cycle, no strobes; fresh refill afterwards completes 256 beats.
//  6 L1_BIU_TIMEOUT_EN, TIMEOUT_CYC=16, ack withheld -> bus_error after 16 cycles; undefined: waits, no error.

Source files
------------

// File: rtl/l1_biu_pkg.sv
// Shared L1 BIU definitions: line geometry and FSM state encoding, also used by the L1 cache.
package l1_biu_pkg;
    localparam int L1_LINE_WID   = 8;
    localparam int L1_LINE_BYTES = 1 << L1_LINE_WID;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LINE = 3'd1,
        ST_SRD  = 3'd2,
        ST_SWR  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } biu_state_t;
endpackage

// File: rtl/l1_biu_watchdog.sv
// Per-beat watchdog: counts cycles a bus request waits without ack/err and flags a timeout.
module l1_biu_watchdog #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Fires on the TIMEOUT_CYC-th consecutive waiting cycle.
    assign timeout = active && !clear && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear || !active) begin
            cnt <= '0;
        end else if (!timeout) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/l1_refill_biu.sv
// L1 I-cache refill / uncached bus-interface engine on a byte-wide request/ack bus.
// Optional per-beat bus watchdog enabled by defining L1_BIU_TIMEOUT_EN.
module l1_refill_biu
    import l1_biu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int LINE_WID    = L1_LINE_WID,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_line_req,
    input  logic                  read_req,
    input  logic                  write_through_req,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic [7:0]            wt_data,
    output logic [7:0]            line_data,
    output logic [LINE_WID-1:0]   addr_count,
    output logic                  line_write,
    output logic                  cache_entry_refill,
    output logic                  trans_rdy,
    output logic                  bus_error,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    output logic [2:0]            state_dbg
);
    // Bus handshake: bus_req holds high (with stable bus_addr/bus_we/bus_wdata) until a
    // one-cycle bus_ack or bus_err completes the beat; bus_err wins when both are high.
    biu_state_t                     state;
    logic [LINE_WID-1:0]            count;
    logic [LINE_WID-1:0]            count_next;
    logic [ADDR_WIDTH-LINE_WID-1:0] base;
    logic                           timeout;
    logic                           beat_fail;
    logic                           last_beat;

    assign count_next = count + 1'b1;
    assign beat_fail  = bus_err || timeout;
    assign last_beat  = (count == {LINE_WID{1'b1}});
    assign state_dbg  = state;

`ifdef L1_BIU_TIMEOUT_EN
    l1_biu_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (bus_req),
        .clear   (bus_ack || bus_err),
        .timeout (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            count              <= '0;
            base               <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
        end else begin
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (read_line_req) begin
                        state    <= ST_LINE;
                        base     <= pa[ADDR_WIDTH-1:LINE_WID];
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= {pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
                    end else if (read_req) begin
                        state    <= ST_SRD;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= pa;
                    end else if (write_through_req) begin
                        state     <= ST_SWR;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= pa;
                        bus_wdata <= wt_data;
                    end
                end
                ST_LINE: begin
                    if (beat_fail) begin
                        state     <= ST_ERR;
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (bus_ack) begin
                        line_write <= 1'b1;
                        line_data  <= bus_rdata;
                        addr_count <= count;
                        count      <= count_next;
                        bus_addr   <= {base, count_next};
                        // The final byte write coincides with the tag update strobe.
                        if (last_beat) begin
                            state              <= ST_DONE;
                            bus_req            <= 1'b0;
                            cache_entry_refill <= 1'b1;
                            trans_rdy          <= 1'b1;
                        end
                    end
                end
                ST_SRD: begin
                    if (beat_fail) begin
                        state     <= ST_ERR;
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (bus_ack) begin
                        state     <= ST_DONE;
                        bus_req   <= 1'b0;
                        line_data <= bus_rdata;
                        trans_rdy <= 1'b1;
                    end
                end
                ST_SWR: begin
                    if (beat_fail) begin
                        state     <= ST_ERR;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (bus_ack) begin
                        state     <= ST_DONE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        trans_rdy <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
